// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops with a registered result and flags, an
// iterative radix-2 shift-add multiplier that back-pressures upstream through
// ready_out, plus downstream stall holding and a synchronous pipeline flush.
module alu_exec #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [7:0]        aluop,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              stall_in,
  input  logic              flush,
  output logic              valid_out,
  output logic [DATA_W-1:0] result,
  output logic              zero_out,
  output logic              branch_taken,
  output logic              align_err,
  output logic              illegal_op,
  output logic              busy
);

  // ALUOP_* codes as produced by the opcode-to-aluop decode
  localparam logic [7:0] ALUOP_ADD      = 8'h01;
  localparam logic [7:0] ALUOP_SUB      = 8'h02;
  localparam logic [7:0] ALUOP_LDB      = 8'h03;
  localparam logic [7:0] ALUOP_LDW      = 8'h04;
  localparam logic [7:0] ALUOP_STB      = 8'h05;
  localparam logic [7:0] ALUOP_STW      = 8'h06;
  localparam logic [7:0] ALUOP_MOV      = 8'h07;
  localparam logic [7:0] ALUOP_BEQ      = 8'h08;
  localparam logic [7:0] ALUOP_JUMP     = 8'h09;
  localparam logic [7:0] ALUOP_TLBWRITE = 8'h0A;
  localparam logic [7:0] ALUOP_IRET     = 8'h0B;
  localparam logic [7:0] ALUOP_MUL      = 8'h0C;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic                accept;
  logic [DATA_W-1:0]   eff_addr;
  logic [DATA_W-1:0]   op_result;
  logic                op_taken;
  logic                op_align;
  logic                op_illegal;
  logic                op_is_mul;
  logic [DATA_W-1:0]   mul_sum;
  logic                mul_last;

  // Upstream may only hand over an op when idle and the output slot is free
  assign ready_out = (state_reg == IDLE) && !(valid_out && stall_in);
  assign accept    = valid_in && ready_out && !flush;
  assign busy      = (state_reg == MUL_RUN);

  // One multiplier iteration: conditional add of the shifted multiplicand
  assign mul_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_last = (cnt_reg == LAST_ITER);

  // Single-cycle op decode and evaluation
  always_comb begin
    eff_addr   = src_a + src_b;
    op_result  = '0;
    op_taken   = 1'b0;
    op_align   = 1'b0;
    op_illegal = 1'b0;
    op_is_mul  = 1'b0;
    case (aluop)
      ALUOP_ADD:                  op_result = src_a + src_b;
      ALUOP_SUB:                  op_result = src_a - src_b;
      ALUOP_LDB, ALUOP_STB:       op_result = eff_addr;
      ALUOP_LDW, ALUOP_STW: begin
        op_result = eff_addr;
        op_align  = |eff_addr[1:0];
      end
      ALUOP_MOV:                  op_result = src_b;
      ALUOP_BEQ: begin
        op_result = pc_in + imm;
        op_taken  = (src_a == src_b);
      end
      ALUOP_JUMP: begin
        op_result = pc_in + imm;
        op_taken  = 1'b1;
      end
      ALUOP_TLBWRITE, ALUOP_IRET: op_result = src_a;
      ALUOP_MUL:                  op_is_mul = 1'b1;
      default:                    op_illegal = 1'b1;
    endcase
  end

  // Control FSM, multiplier datapath and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      valid_out    <= 1'b0;
      result       <= '0;
      zero_out     <= 1'b0;
      branch_taken <= 1'b0;
      align_err    <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (flush) begin
      // Flush beats both a new accept and a multiplier completion
      state_reg    <= IDLE;
      valid_out    <= 1'b0;
      zero_out     <= 1'b0;
      branch_taken <= 1'b0;
      align_err    <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (op_is_mul) begin
              state_reg  <= MUL_RUN;
              mcand_reg  <= src_a;
              mplier_reg <= src_b;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              valid_out  <= 1'b0;
            end else begin
              valid_out    <= 1'b1;
              result       <= op_result;
              zero_out     <= (op_result == '0);
              branch_taken <= op_taken;
              align_err    <= op_align;
              illegal_op   <= op_illegal;
            end
          end else if (!stall_in) begin
            valid_out <= 1'b0;
          end
        end
        MUL_RUN: begin
          acc_reg    <= mul_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (mul_last) begin
            state_reg    <= IDLE;
            valid_out    <= 1'b1;
            result       <= mul_sum;
            zero_out     <= (mul_sum == '0);
            branch_taken <= 1'b0;
            align_err    <= 1'b0;
            illegal_op   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Report unknown aluop codes as they are accepted
  always @(posedge clk) begin
    if (reset_n && accept && op_illegal)
      $warning("alu_exec: unknown aluop 0x%02h", aluop);
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, randomized ops against a
// behavioural model, and hand sequences for MUL latency, stall, flush, reset.
module tb_alu_exec;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_LDB = 8'h03,
                         OP_LDW = 8'h04, OP_STB = 8'h05, OP_STW = 8'h06,
                         OP_MOV = 8'h07, OP_BEQ = 8'h08, OP_JUMP = 8'h09,
                         OP_TLBW = 8'h0A, OP_IRET = 8'h0B, OP_MUL = 8'h0C,
                         OP_BAD = 8'hEE;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [7:0]        aluop = '0;
  logic [DATA_W-1:0] src_a = '0, src_b = '0, imm = '0, pc_in = '0;
  logic              stall_in = 1'b0;
  logic              flush = 1'b0;
  logic              valid_out;
  logic [DATA_W-1:0] result;
  logic              zero_out, branch_taken, align_err, illegal_op, busy;

  alu_exec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .aluop(aluop), .src_a(src_a), .src_b(src_b), .imm(imm), .pc_in(pc_in),
    .stall_in(stall_in), .flush(flush), .valid_out(valid_out), .result(result),
    .zero_out(zero_out), .branch_taken(branch_taken), .align_err(align_err),
    .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, pc, im;
    logic [31:0] res;
    logic        zero, taken, align, illegal;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero, taken, align, illegal;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the op table evaluated with plain integer arithmetic
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, b, pc, im);
    exp_t e;
    e.res = 0; e.taken = 0; e.align = 0; e.illegal = 0;
    if (op == OP_ADD) e.res = a + b;
    else if (op == OP_SUB) e.res = a - b;
    else if (op inside {OP_LDB, OP_STB, OP_LDW, OP_STW}) begin
      e.res = a + b;
      e.align = (op == OP_LDW || op == OP_STW) && ((e.res % 4) != 0);
    end
    else if (op == OP_MOV) e.res = b;
    else if (op == OP_BEQ) begin e.res = pc + im; e.taken = (a == b); end
    else if (op == OP_JUMP) begin e.res = pc + im; e.taken = 1; end
    else if (op == OP_TLBW || op == OP_IRET) e.res = a;
    else if (op == OP_MUL) e.res = 32'(longint'(a) * longint'(b));
    else e.illegal = 1;
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Present one op, wait for acceptance and, for MUL, for completion
  task automatic apply_op(input logic [7:0] op, input logic [31:0] a, b, pc, im);
    int guard, lat, bad;
    aluop = op; src_a = a; src_b = b; pc_in = pc; imm = im; valid_in = 1'b1;
    guard = 0;
    while (!ready_out && guard < 64) begin step(); guard++; end
    check("ready_before_accept", 32'(ready_out), 32'd1);
    step();
    valid_in = 1'b0;
    if (op == OP_MUL) begin
      bad = 0; lat = 0;
      if (!busy || ready_out || valid_out) bad++;
      while (!valid_out && lat < 4 * DATA_W) begin
        step(); lat++;
        if (!valid_out && (!busy || ready_out)) bad++;
      end
      check("mul_busy_window", 32'(bad), 32'd0);
      check("mul_latency", 32'(lat), 32'(DATA_W));
      check("mul_busy_clear", 32'(busy), 32'd0);
    end
    $display("op=%02h a=%08h b=%08h pc=%08h imm=%08h -> valid=%b result=%08h z=%b br=%b al=%b il=%b",
             op, a, b, pc, im, valid_out, result, zero_out, branch_taken, align_err, illegal_op);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(valid_out), 32'd1);
    check({tag, ".result"}, result, e.res);
    check({tag, ".zero"}, 32'(zero_out), 32'(e.zero));
    check({tag, ".taken"}, 32'(branch_taken), 32'(e.taken));
    check({tag, ".align"}, 32'(align_err), 32'(e.align));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(e.illegal));
  endtask

  vec_t vecs[14];

  initial begin
    exp_t e;
    int   cnt;
    logic [7:0] codes[14];

    vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h2, 0, 0, 32'h1, 0, 0, 0, 0};
    vecs[1]  = '{OP_SUB,  32'h5, 32'h5, 0, 0, 32'h0, 1, 0, 0, 0};
    vecs[2]  = '{OP_BEQ,  32'h7, 32'h7, 32'h100, 32'hFFFFFFF0, 32'hF0, 0, 1, 0, 0};
    vecs[3]  = '{OP_BEQ,  32'h7, 32'h8, 32'h100, 32'hFFFFFFF0, 32'hF0, 0, 0, 0, 0};
    vecs[4]  = '{OP_JUMP, 32'h1, 32'h2, 32'h100, 32'hFFFFFFF0, 32'hF0, 0, 1, 0, 0};
    vecs[5]  = '{OP_LDW,  32'h1000, 32'h2, 0, 0, 32'h1002, 0, 0, 1, 0};
    vecs[6]  = '{OP_LDB,  32'h1000, 32'h2, 0, 0, 32'h1002, 0, 0, 0, 0};
    vecs[7]  = '{OP_STW,  32'h1000, 32'h4, 0, 0, 32'h1004, 0, 0, 0, 0};
    vecs[8]  = '{OP_STW,  32'h1001, 32'h0, 0, 0, 32'h1001, 0, 0, 1, 0};
    vecs[9]  = '{OP_MOV,  32'h3, 32'h9, 0, 0, 32'h9, 0, 0, 0, 0};
    vecs[10] = '{OP_TLBW, 32'h55, 32'h1, 0, 0, 32'h55, 0, 0, 0, 0};
    vecs[11] = '{OP_IRET, 32'h0, 32'h1, 0, 0, 32'h0, 1, 0, 0, 0};
    vecs[12] = '{OP_BAD,  32'h3, 32'h4, 0, 0, 32'h0, 1, 0, 0, 1};
    vecs[13] = '{OP_MUL,  32'h00012345, 32'h100, 0, 0, 32'h01234500, 0, 0, 0, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 32'(valid_out), 0);
    check("rst.result", result, 0);
    check("rst.zero", 32'(zero_out), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.ready", 32'(ready_out), 1);
    @(negedge clk) reset_n = 1'b1;
    step();

    // Directed vector table, back to back
    for (int i = 0; i < 14; i++) begin
      apply_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].im);
      e.res = vecs[i].res; e.zero = vecs[i].zero; e.taken = vecs[i].taken;
      e.align = vecs[i].align; e.illegal = vecs[i].illegal;
      check_out($sformatf("vec%0d", i), e);
    end

    // Full-width MUL wraps modulo 2^32
    apply_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("mul_ff.result", result, 32'h1);

    // Randomized ops against the model
    codes = '{OP_ADD, OP_SUB, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_MOV, OP_BEQ,
              OP_JUMP, OP_TLBW, OP_IRET, OP_MUL, OP_BAD, 8'h00};
    for (int i = 0; i < 150; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b, pc, im;
      op = codes[$urandom_range(0, 13)];
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = a & 32'hFF;
      pc = $urandom; im = $urandom;
      apply_op(op, a, b, pc, im);
      check_out($sformatf("rnd%0d", i), model(op, a, b, pc, im));
    end
    step();

    // Stall holds the result and blocks a pending MOV
    apply_op(OP_ADD, 32'h1, 32'h2, 0, 0);
    stall_in = 1'b1; valid_in = 1'b1; aluop = OP_MOV; src_a = 0; src_b = 32'h9;
    #1;
    check("stall.ready0", 32'(ready_out), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.valid_hold", 32'(valid_out), 1);
      check("stall.result_hold", result, 32'h3);
      check("stall.ready", 32'(ready_out), 0);
    end
    stall_in = 1'b0;
    #1;
    check("stall.release_ready", 32'(ready_out), 1);
    step();
    valid_in = 1'b0;
    check("stall.mov_result", result, 32'h9);
    check("stall.mov_valid", 32'(valid_out), 1);
    step();
    check("stall.consumed", 32'(valid_out), 0);

    // Flush mid-MUL: no result ever emerges
    aluop = OP_MUL; src_a = 32'h7; src_b = 32'h6; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush.valid", 32'(valid_out), 0);
    check("flush.busy", 32'(busy), 0);
    check("flush.ready", 32'(ready_out), 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(); if (valid_out) cnt++; end
    check("flush.no_result", 32'(cnt), 0);

    // Flush drops an op presented the same cycle and clears flags
    apply_op(OP_JUMP, 0, 0, 32'h40, 32'h4);
    check("flush_pre.taken", 32'(branch_taken), 1);
    flush = 1'b1; valid_in = 1'b1; aluop = OP_ADD; src_a = 1; src_b = 1;
    step();
    flush = 1'b0; valid_in = 1'b0;
    check("flush_same.valid", 32'(valid_out), 0);
    check("flush_same.taken", 32'(branch_taken), 0);

    // Asynchronous reset mid-MUL
    apply_op(OP_ADD, 32'h10, 32'h20, 0, 0);
    aluop = OP_MUL; src_a = 32'h3; src_b = 32'h5; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (9) step();
    #2 reset_n = 1'b0;
    #1;
    check("arst.busy", 32'(busy), 0);
    check("arst.valid", 32'(valid_out), 0);
    check("arst.result", result, 0);
    check("arst.zero", 32'(zero_out), 0);
    check("arst.taken", 32'(branch_taken), 0);
    check("arst.ready", 32'(ready_out), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(); if (valid_out || busy) cnt++; end
    check("arst.no_result", 32'(cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
